// File: rtl/rf_access_arbiter_if.sv
// Bus bundle between the two requesters / register file and rf_access_arbiter.
// master : requester side plus register file read data (the environment)
// slave  : the arbiter itself
interface rf_access_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    // requester 0 (instruction control path)
    logic                  REQ0;
    logic                  WE0;
    logic [ADDR_WIDTH-1:0] RA1_0;
    logic [ADDR_WIDTH-1:0] RA2_0;
    logic [ADDR_WIDTH-1:0] WA0;
    logic [DATA_WIDTH-1:0] WD0;
    logic                  LOCK0;
    logic                  GNT0;
    logic                  ACK0;

    // requester 1 (debug / loader port)
    logic                  REQ1;
    logic                  WE1;
    logic [ADDR_WIDTH-1:0] RA1_1;
    logic [ADDR_WIDTH-1:0] RA2_1;
    logic [ADDR_WIDTH-1:0] WA1;
    logic [DATA_WIDTH-1:0] WD1;
    logic                  LOCK1;
    logic                  GNT1;
    logic                  ACK1;

    // shared read result and status
    logic [DATA_WIDTH-1:0] RDATA1;
    logic [DATA_WIDTH-1:0] RDATA2;
    logic                  BUSY;
    logic                  OWNER;

    // register file side
    logic                  READ;
    logic                  WRITE;
    logic [ADDR_WIDTH-1:0] ADDR_R1;
    logic [ADDR_WIDTH-1:0] ADDR_R2;
    logic [ADDR_WIDTH-1:0] ADDR_W;
    logic [DATA_WIDTH-1:0] DATA_W;
    logic [DATA_WIDTH-1:0] DATA_R1;
    logic [DATA_WIDTH-1:0] DATA_R2;

    modport master (
        output REQ0, WE0, RA1_0, RA2_0, WA0, WD0, LOCK0,
        output REQ1, WE1, RA1_1, RA2_1, WA1, WD1, LOCK1,
        output DATA_R1, DATA_R2,
        input  GNT0, ACK0, GNT1, ACK1,
        input  RDATA1, RDATA2, BUSY, OWNER,
        input  READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W
    );

    modport slave (
        input  REQ0, WE0, RA1_0, RA2_0, WA0, WD0, LOCK0,
        input  REQ1, WE1, RA1_1, RA2_1, WA1, WD1, LOCK1,
        input  DATA_R1, DATA_R2,
        output GNT0, ACK0, GNT1, ACK1,
        output RDATA1, RDATA2, BUSY, OWNER,
        output READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W
    );
endinterface

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: round-robin arbiter and sequencer giving one of two
// requesters exclusive use of the register file's two read ports and one
// write port per transaction. Flow: IDLE -> ISSUE -> (WAIT x RF_LAT) -> DONE.
// Optional feature macro: RFARB_LOCK_EN (owner may chain transactions from
// DONE straight back to ISSUE while it holds LOCK and REQ).
module rf_access_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int RF_LAT     = 1
) (
    input  logic               CLK,
    input  logic               RST,
    rf_access_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int               CNT_W     = (RF_LAT > 1) ? $clog2(RF_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RF_LAT - 1);

    // ---------------------------------------------------------------
    // Per-requester views of the bus so selection is a simple index
    // ---------------------------------------------------------------
    logic [1:0]            req_vec;
    logic [1:0]            we_vec;
    logic [1:0]            lock_vec;
    logic [ADDR_WIDTH-1:0] ra1_vec [2];
    logic [ADDR_WIDTH-1:0] ra2_vec [2];
    logic [ADDR_WIDTH-1:0] wa_vec  [2];
    logic [DATA_WIDTH-1:0] wd_vec  [2];

    assign req_vec    = {bus.REQ1, bus.REQ0};
    assign we_vec     = {bus.WE1, bus.WE0};
    assign lock_vec   = {bus.LOCK1, bus.LOCK0};
    assign ra1_vec[0] = bus.RA1_0;
    assign ra1_vec[1] = bus.RA1_1;
    assign ra2_vec[0] = bus.RA2_0;
    assign ra2_vec[1] = bus.RA2_1;
    assign wa_vec[0]  = bus.WA0;
    assign wa_vec[1]  = bus.WA1;
    assign wd_vec[0]  = bus.WD0;
    assign wd_vec[1]  = bus.WD1;

    // ---------------------------------------------------------------
    // State and latched transaction fields
    // ---------------------------------------------------------------
    logic [1:0]            state_reg,  state_next;
    logic                  owner_reg,  owner_next;
    logic                  we_reg,     we_next;
    logic [ADDR_WIDTH-1:0] ra1_reg,    ra1_next;
    logic [ADDR_WIDTH-1:0] ra2_reg,    ra2_next;
    logic [ADDR_WIDTH-1:0] wa_reg,     wa_next;
    logic [DATA_WIDTH-1:0] wd_reg,     wd_next;
    logic [CNT_W-1:0]      cnt_reg,    cnt_next;
    logic [DATA_WIDTH-1:0] rdata1_reg, rdata1_next;
    logic [DATA_WIDTH-1:0] rdata2_reg, rdata2_next;

    logic winner;
    logic lock_hold;
    logic load_fields;
    logic sel;

    // Round-robin pick: on a tie the requester that did not own last wins
    always_comb begin
        winner = owner_reg;
        if (req_vec == 2'b11) begin
            winner = ~owner_reg;
        end else if (req_vec[1]) begin
            winner = 1'b1;
        end else if (req_vec[0]) begin
            winner = 1'b0;
        end
    end

`ifdef RFARB_LOCK_EN
    // Owner keeps the port if it still requests with LOCK high at DONE
    assign lock_hold = (state_reg == DONE) && lock_vec[owner_reg] && req_vec[owner_reg];
`else
    // Lock inputs have no effect in this build
    logic unused_lock;
    assign unused_lock = ^lock_vec;
    assign lock_hold   = 1'b0;
`endif

    // Fields come from the arbitration winner in IDLE, or from the locked owner in DONE
    assign load_fields = ((state_reg == IDLE) && (req_vec != 2'b00)) || lock_hold;
    assign sel         = (state_reg == IDLE) ? winner : owner_reg;

    // Next-state, field latching and read-data capture
    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        we_next     = we_reg;
        ra1_next    = ra1_reg;
        ra2_next    = ra2_reg;
        wa_next     = wa_reg;
        wd_next     = wd_reg;
        cnt_next    = cnt_reg;
        rdata1_next = rdata1_reg;
        rdata2_next = rdata2_reg;

        case (state_reg)
            IDLE: begin
                if (req_vec != 2'b00) begin
                    state_next = ISSUE;
                    owner_next = winner;
                end
            end
            ISSUE: begin
                if (we_reg) begin
                    state_next = DONE;
                end else begin
                    state_next = WAIT;
                    cnt_next   = WAIT_LAST;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    rdata1_next = bus.DATA_R1;
                    rdata2_next = bus.DATA_R2;
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DONE: begin
                state_next = lock_hold ? ISSUE : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load_fields) begin
            we_next  = we_vec[sel];
            ra1_next = ra1_vec[sel];
            ra2_next = ra2_vec[sel];
            wa_next  = wa_vec[sel];
            wd_next  = wd_vec[sel];
        end
    end

    // State register; reset drops any in-flight transaction
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            owner_reg  <= 1'b1;
            we_reg     <= 1'b0;
            ra1_reg    <= '0;
            ra2_reg    <= '0;
            wa_reg     <= '0;
            wd_reg     <= '0;
            cnt_reg    <= '0;
            rdata1_reg <= '0;
            rdata2_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            we_reg     <= we_next;
            ra1_reg    <= ra1_next;
            ra2_reg    <= ra2_next;
            wa_reg     <= wa_next;
            wd_reg     <= wd_next;
            cnt_reg    <= cnt_next;
            rdata1_reg <= rdata1_next;
            rdata2_reg <= rdata2_next;
        end
    end

    // ---------------------------------------------------------------
    // Register file strobes and addresses, zero outside ISSUE/WAIT
    // ---------------------------------------------------------------
    logic                  read_strobe;
    logic                  write_strobe;
    logic [ADDR_WIDTH-1:0] addr_r1;
    logic [ADDR_WIDTH-1:0] addr_r2;
    logic [ADDR_WIDTH-1:0] addr_w;
    logic [DATA_WIDTH-1:0] data_w;

    // READ spans ISSUE and WAIT with addresses held; WRITE is ISSUE only
    always_comb begin
        read_strobe  = 1'b0;
        write_strobe = 1'b0;
        addr_r1      = '0;
        addr_r2      = '0;
        addr_w       = '0;
        data_w       = '0;
        if (!we_reg && ((state_reg == ISSUE) || (state_reg == WAIT))) begin
            read_strobe = 1'b1;
            addr_r1     = ra1_reg;
            addr_r2     = ra2_reg;
        end
        if (we_reg && (state_reg == ISSUE)) begin
            write_strobe = 1'b1;
            addr_w       = wa_reg;
            data_w       = wd_reg;
        end
    end

    // Grant and acknowledge pulses, one per requester
    logic [1:0] gnt_vec;
    logic [1:0] ack_vec;
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign gnt_vec[gi] = (state_reg == ISSUE) && (owner_reg == 1'(gi));
            assign ack_vec[gi] = (state_reg == DONE)  && (owner_reg == 1'(gi));
        end
    endgenerate

    assign bus.GNT0    = gnt_vec[0];
    assign bus.GNT1    = gnt_vec[1];
    assign bus.ACK0    = ack_vec[0];
    assign bus.ACK1    = ack_vec[1];
    assign bus.READ    = read_strobe;
    assign bus.WRITE   = write_strobe;
    assign bus.ADDR_R1 = addr_r1;
    assign bus.ADDR_R2 = addr_r2;
    assign bus.ADDR_W  = addr_w;
    assign bus.DATA_W  = data_w;
    assign bus.RDATA1  = rdata1_reg;
    assign bus.RDATA2  = rdata2_reg;
    assign bus.BUSY    = (state_reg != IDLE);
    assign bus.OWNER   = owner_reg;
endmodule

// File: tb/tb_rf_access_arbiter.sv
// Randomized self-checking bench for rf_access_arbiter. A transaction-level
// reference model predicts grants (round-robin), timing, strobes and read data.
module tb_rf_access_arbiter;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int LAT  = 1;
    localparam int NREG = 1 << AW;
`ifdef RFARB_LOCK_EN
    localparam bit LOCK_BUILD = 1'b1;
`else
    localparam bit LOCK_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic          we;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          lock;
    } txn_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    rf_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    rf_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RF_LAT(LAT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    function automatic logic [DW-1:0] seed_val(input int i);
        if (i == 3) return 32'h11;
        if (i == 7) return 32'h22;
        return DW'(i) * 32'h0001_0003 + 32'hA5;
    endfunction

    // Register file environment: reloads on reset, read data LAT cycles late
    logic [DW-1:0] rf    [NREG];
    logic [DW-1:0] pipe1 [LAT];
    logic [DW-1:0] pipe2 [LAT];
    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) rf[i] <= seed_val(i);
        end else if (bus.WRITE) begin
            rf[bus.ADDR_W] <= bus.DATA_W;
        end
        pipe1[0] <= rf[bus.ADDR_R1];
        pipe2[0] <= rf[bus.ADDR_R2];
        for (int i = 1; i < LAT; i++) begin
            pipe1[i] <= pipe1[i-1];
            pipe2[i] <= pipe2[i-1];
        end
    end
    assign bus.DATA_R1 = pipe1[LAT-1];
    assign bus.DATA_R2 = pipe2[LAT-1];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // requesters
    txn_t cur       [2];
    bit   cur_v     [2];
    int   backlog   [2];
    int   lock_left [2];
    int   gap_pct   = 0;
    bit   lock_rand = 1'b0;

    // reference model
    logic [DW-1:0] exp_mem [NREG];
    bit            m_act     = 1'b0;
    int            m_own     = 0;
    txn_t          m_txn;
    int            m_gnt     = 0;
    int            m_ack     = 0;
    logic [DW-1:0] m_rd1     = '0;
    logic [DW-1:0] m_rd2     = '0;
    logic [DW-1:0] exp_rd1   = '0;
    logic [DW-1:0] exp_rd2   = '0;
    int            last_own  = 1;
    int            idle_from = 0;
    bit            lock_pend = 1'b0;
    bit            rst_pend  = 1'b0;
    bit [1:0]      prev_req  = 2'b00;
    bit            wait_reset_armed = 1'b0;
    int            gnt_log [$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic we, input int ra1, input int ra2,
                                input int wa, input logic [DW-1:0] wd);
        txn_t t;
        t.we   = we;
        t.ra1  = AW'(ra1);
        t.ra2  = AW'(ra2);
        t.wa   = AW'(wa);
        t.wd   = wd;
        t.lock = 1'b0;
        return t;
    endfunction

    task automatic new_txn(input int r);
        txn_t t;
        t = mk(1'($urandom_range(1, 0)), int'($urandom_range(NREG - 1, 0)),
               int'($urandom_range(NREG - 1, 0)), int'($urandom_range(NREG - 1, 0)), $urandom);
        if (lock_rand) begin
            t.lock = 1'($urandom_range(1, 0));
        end else if (lock_left[r] > 0) begin
            t.lock = 1'b1;
            lock_left[r]--;
        end
        cur[r]   = t;
        cur_v[r] = 1'b1;
        backlog[r]--;
    endtask

    task automatic drive();
        bus.REQ0  = cur_v[0];
        bus.WE0   = cur[0].we;
        bus.RA1_0 = cur[0].ra1;
        bus.RA2_0 = cur[0].ra2;
        bus.WA0   = cur[0].wa;
        bus.WD0   = cur[0].wd;
        bus.LOCK0 = cur_v[0] & cur[0].lock;
        bus.REQ1  = cur_v[1];
        bus.WE1   = cur[1].we;
        bus.RA1_1 = cur[1].ra1;
        bus.RA2_1 = cur[1].ra2;
        bus.WA1   = cur[1].wa;
        bus.WD1   = cur[1].wd;
        bus.LOCK1 = cur_v[1] & cur[1].lock;
        prev_req  = RST ? 2'b00 : {cur_v[1], cur_v[0]};
    endtask

    // One clock: predict, compare every output, then advance the requesters
    task automatic step();
        logic [1:0]    e_gnt;
        logic [1:0]    e_ack;
        logic          e_rd;
        logic          e_wr;
        logic          e_busy;
        logic [AW-1:0] e_a1;
        logic [AW-1:0] e_a2;
        logic [AW-1:0] e_aw;
        logic [DW-1:0] e_dw;
        bit            just_acked;
        int            w;
        @(posedge CLK);
        #1;
        cyc++;
        e_gnt = '0; e_ack = '0; e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0;
        e_a1 = '0; e_a2 = '0; e_aw = '0; e_dw = '0;
        just_acked = 1'b0;

        if (rst_pend) begin
            rst_pend  = 1'b0;
            RST       = 1'b0;
            m_act     = 1'b0;
            last_own  = 1;
            lock_pend = 1'b0;
            idle_from = cyc;
            exp_rd1   = '0;
            exp_rd2   = '0;
            for (int i = 0; i < NREG; i++) exp_mem[i] = seed_val(i);
        end else if (!m_act) begin
            w = -1;
            if (lock_pend) begin
                w = last_own;
            end else if ((cyc - 1 >= idle_from) && (prev_req != 2'b00)) begin
                w = (prev_req == 2'b11) ? 1 - last_own : (prev_req[1] ? 1 : 0);
            end
            lock_pend = 1'b0;
            if (w >= 0) begin
                m_act    = 1'b1;
                m_own    = w;
                last_own = w;
                m_txn    = cur[w];
                m_gnt    = cyc;
                m_ack    = m_txn.we ? cyc + 1 : cyc + 1 + LAT;
                gnt_log.push_back(w);
                if (m_txn.we) begin
                    exp_mem[m_txn.wa] = m_txn.wd;
                end else begin
                    m_rd1 = exp_mem[m_txn.ra1];
                    m_rd2 = exp_mem[m_txn.ra2];
                end
            end
        end

        if (m_act) begin
            e_busy = 1'b1;
            if (cyc == m_gnt) begin
                e_gnt[m_own] = 1'b1;
                if (m_txn.we) begin
                    e_wr = 1'b1;
                    e_aw = m_txn.wa;
                    e_dw = m_txn.wd;
                end
            end
            if (!m_txn.we && cyc < m_ack) begin
                e_rd = 1'b1;
                e_a1 = m_txn.ra1;
                e_a2 = m_txn.ra2;
            end
            if (cyc == m_ack) begin
                e_ack[m_own] = 1'b1;
                if (!m_txn.we) begin
                    exp_rd1 = m_rd1;
                    exp_rd2 = m_rd2;
                end
            end
        end

        check("gnt",     DW'({bus.GNT1, bus.GNT0}), DW'(e_gnt));
        check("ack",     DW'({bus.ACK1, bus.ACK0}), DW'(e_ack));
        check("read",    DW'(bus.READ),  DW'(e_rd));
        check("write",   DW'(bus.WRITE), DW'(e_wr));
        check("rw_excl", DW'(bus.READ & bus.WRITE), '0);
        check("addr_r1", DW'(bus.ADDR_R1), DW'(e_a1));
        check("addr_r2", DW'(bus.ADDR_R2), DW'(e_a2));
        check("addr_w",  DW'(bus.ADDR_W),  DW'(e_aw));
        check("data_w",  bus.DATA_W, e_dw);
        check("busy",    DW'(bus.BUSY),  DW'(e_busy));
        check("owner",   DW'(bus.OWNER), DW'(last_own));
        check("rdata1",  bus.RDATA1, exp_rd1);
        check("rdata2",  bus.RDATA2, exp_rd2);

        if (m_act && cyc == m_ack) begin
            $display("txn cycle=%0d req=%0d %s ra1=%0d ra2=%0d wa=%0d wd=%h rd1=%h rd2=%h",
                     cyc, m_own, m_txn.we ? "write" : "read", m_txn.ra1, m_txn.ra2,
                     m_txn.wa, m_txn.wd, exp_rd1, exp_rd2);
            m_act        = 1'b0;
            idle_from    = cyc + 1;
            cur_v[m_own] = 1'b0;
            just_acked   = 1'b1;
        end

        if (wait_reset_armed && m_act && !m_txn.we && cyc == m_gnt + 1) begin
            wait_reset_armed = 1'b0;
            RST        = 1'b1;
            rst_pend   = 1'b1;
            cur_v[0]   = 1'b0;
            cur_v[1]   = 1'b0;
            backlog[0] = 0;
            backlog[1] = 0;
        end

        for (int r = 0; r < 2; r++) begin
            if (!cur_v[r] && backlog[r] > 0 && int'($urandom_range(99, 0)) >= gap_pct) new_txn(r);
        end
        if (just_acked) lock_pend = LOCK_BUILD && cur_v[m_own] && cur[m_own].lock;
        drive();
    endtask

    task automatic drain(input int limit);
        int  n;
        bit  pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < limit) begin
            step();
            n++;
            pending = m_act || lock_pend || rst_pend || cur_v[0] || cur_v[1] ||
                      backlog[0] > 0 || backlog[1] > 0;
        end
        check("drain", DW'(pending), '0);
        step();
        step();
    endtask

    task automatic pulse_reset();
        RST        = 1'b1;
        rst_pend   = 1'b1;
        cur_v[0]   = 1'b0;
        cur_v[1]   = 1'b0;
        backlog[0] = 0;
        backlog[1] = 0;
        drive();
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order [4];
        for (int r = 0; r < 2; r++) begin
            cur[r] = mk(1'b0, 0, 0, 0, '0);
            cur_v[r] = 1'b0;
            backlog[r] = 0;
            lock_left[r] = 0;
        end
        drive();
        repeat (3) @(posedge CLK);
        #1;
        pulse_reset();

        // single write from requester 0
        cur[0] = mk(1'b1, 0, 0, 5, 32'hDEADBEEF);
        cur_v[0] = 1'b1;
        drive();
        drain(50);

        // single read from requester 1: regs 3 and 7
        cur[1] = mk(1'b0, 3, 7, 0, '0);
        cur_v[1] = 1'b1;
        drive();
        drain(50);

        // both held from reset: alternate starting with requester 0
        pulse_reset();
        gnt_log.delete();
        gap_pct = 0;
        backlog[0] = 4;
        backlog[1] = 4;
        drain(200);
        check("p3_grants", DW'(gnt_log.size()), DW'(8));
        if (gnt_log.size() >= 8) begin
            for (int i = 0; i < 8; i++) check("p3_order", DW'(gnt_log[i]), DW'(i % 2));
        end

        // reset during WAIT of a read, then a fresh read
        wait_reset_armed = 1'b1;
        cur[1] = mk(1'b0, 9, 10, 0, '0);
        cur_v[1] = 1'b1;
        drive();
        drain(50);
        cur[0] = mk(1'b0, 3, 7, 0, '0);
        cur_v[0] = 1'b1;
        drive();
        drain(50);

        // randomized traffic, sparse then dense
        lock_rand = 1'b1;
        gap_pct = 60;
        backlog[0] = 40;
        backlog[1] = 40;
        drain(4000);
        gap_pct = 10;
        backlog[0] = 30;
        backlog[1] = 30;
        drain(4000);
        lock_rand = 1'b0;

        // requester 0 locks for three chained transactions while 1 waits
        pulse_reset();
        gnt_log.delete();
        gap_pct = 0;
        lock_left[0] = 3;
        lock_left[1] = 0;
        backlog[0] = 5;
        backlog[1] = 3;
        drain(300);
        if (LOCK_BUILD) exp_order = '{0, 0, 0, 1};
        else            exp_order = '{0, 1, 0, 1};
        check("lock_grants", DW'(gnt_log.size()), DW'(8));
        if (gnt_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("lock_order", DW'(gnt_log[i]), DW'(exp_order[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/rf_access_arbiter.md
# rf_access_arbiter

Two-requester arbiter and sequencer for the shared register file. It grants the register file's two read ports and one write port to one requester at a time, using round-robin priority. Requester 0 is the instruction control path; requester 1 is the debug/loader port. It drives the register file READ/WRITE strobes and addresses, waits out the read latency, and returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width
- RF_LAT, 1, register file read latency in cycles (≥1); READ held this many cycles after issue

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- REQ0, REQ1  in  1  transaction request, held until GNTn
- WE0, WE1  in  1  1 = write transaction, 0 = read transaction
- RA1_0, RA2_0, RA1_1, RA2_1  in  ADDR_WIDTH  read addresses, per requester
- WA0, WA1  in  ADDR_WIDTH  write address, per requester
- WD0, WD1  in  DATA_WIDTH  write data, per requester
- LOCK0, LOCK1  in  1  keep ownership for the next transaction (used only with RFARB_LOCK_EN)
- GNT0, GNT1  out  1  one-cycle pulse: request accepted, fields latched
- ACK0, ACK1  out  1  one-cycle pulse: transaction complete
- RDATA1, RDATA2  out  DATA_WIDTH  read result, valid while ACKn=1 for a read; held until the next read completes
- READ, WRITE  out  1  register file strobes
- ADDR_R1, ADDR_R2, ADDR_W  out  ADDR_WIDTH  register file addresses
- DATA_W  out  DATA_WIDTH  register file write data
- DATA_R1, DATA_R2  in  DATA_WIDTH  register file read data
- BUSY  out  1  high in every state except IDLE
- OWNER  out  1  index of the current or last granted requester

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - REQ0/REQ1 are sampled.
  - If any request is present, the winner's WE, RA1, RA2, WA and WD are latched; OWNER is set to the winner; next state is ISSUE.
- Arbitration:
  - With a single request, that requester wins.
  - With both requesting, the requester ≠ OWNER wins (round-robin).
  - OWNER resets to 1, so requester 0 wins the first tie.
- ISSUE, one cycle:
  - GNTowner=1.
  - Write: WRITE=1, ADDR_W and DATA_W driven from the latched fields; next state DONE.
  - Read: READ=1, ADDR_R1 and ADDR_R2 driven; next state WAIT.
- WAIT, RF_LAT cycles:
  - READ=1 and addresses held.
  - On the last WAIT edge, DATA_R1/DATA_R2 are captured into RDATA1/RDATA2; next state DONE.
- DONE, one cycle: ACKowner=1; next state IDLE.
- REQn is sampled only in IDLE. A requester wanting a single transaction deasserts REQn no later than its ACK cycle; a REQn still high in IDLE starts a new transaction.
- READ and WRITE are never both high. Address and data outputs return to 0 in IDLE and DONE.
- Requests arriving while BUSY wait; they are not lost as long as the requester holds REQ.

## Timing
- Reset values: READ=0, WRITE=0, GNT0/1=0, ACK0/1=0, ADDR_R1/R2/W=0, DATA_W=0, RDATA1/2=0, BUSY=0, OWNER=1; state IDLE.
- RST high in any state: at the next edge the FSM returns to IDLE and all outputs take their reset values. The in-flight transaction is dropped with no ACK, and a pending write strobe is removed.
- Write: REQ sampled at edge 0 → GNT and WRITE in cycle 1 → ACK in cycle 2 → IDLE in cycle 3.
- Read: GNT and READ in cycle 1 → WAIT in cycles 2..1+RF_LAT → ACK and RDATA in cycle 2+RF_LAT.
- Minimum spacing between grants: 3 cycles for writes, 3+RF_LAT cycles for reads, because DONE always returns through IDLE.
- Simultaneous REQ0 and REQ1 in IDLE: exactly one GNT, chosen by the round-robin rule. The loser is granted after the winner's ACK if it still requests.

## Configuration
- Macro RFARB_LOCK_EN.
- Defined:
  - In DONE, if LOCKowner=1 and REQowner=1, the next state goes directly to ISSUE for the same owner, with fields latched in DONE and arbitration skipped. This gives back-to-back transactions with no IDLE cycle.
  - The lock persists while LOCK and REQ stay high.
- Undefined: LOCK0/LOCK1 are ignored, and every transaction goes through IDLE and arbitration.

## Test plan
- Reset, then REQ0=1, WE0=1, WA0=5, WD0=0xDEADBEEF → WRITE=1, ADDR_W=5, DATA_W=0xDEADBEEF and GNT0 in cycle 1; ACK0 in cycle 2; BUSY low in cycle 3.
- REQ1 read with RA1_1=3, RA2_1=7, register file returning 0x11/0x22, RF_LAT=1 → READ high in cycles 1–2; ACK1 in cycle 3 with RDATA1=0x11, RDATA2=0x22.
- REQ0 and REQ1 both held from reset → grant order 0,1,0,1; never two GNTs in one cycle; OWNER alternates.
- RST asserted during WAIT of a read → next cycle READ=0, BUSY=0, no ACK; a fresh request afterwards completes normally.
- With RFARB_LOCK_EN and LOCK0=REQ0=1 while REQ1=1 → requester 0 keeps consecutive grants with no IDLE cycle; when LOCK0 drops, the next grant goes to requester 1. Without the macro, grants alternate.
